serv_rf_ram_port: RTL and testbench

Bit-serial to word-parallel bridge between the SERV core's register-file interface (`o_wreg*`/`o_wen*`/`o_wdata*`/`o_rreg*` in, `i_rdata0`/`i_rdata1` out) and a simple dual-port synchronous RAM that is `WIDTH` bits wide. It is the memory-side end of that interface. It gathers 1-bit write streams into RAM words. It fetches RAM words and replays them as two parallel 1-bit read streams, rs1 and rs2, LSB first. It sits between the core and the RF RAM macro.

---
 rtl/serv_rf_ram_port.sv | 192 +++++++++++++++++++
 tb/tb_serv_rf_ram_port.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_ram_port.sv
// serv_rf_ram_port: bridges SERV's bit-serial register-file interface to a WIDTH-bit dual-port RAM.
// Optional macro SERV_RF_CSR_EN widens register indices to 6 bits for the four CSR slots (32..35).
module serv_rf_ram_port #(
  parameter int WIDTH = 8,
`ifdef SERV_RF_CSR_EN
  parameter int RW = 6,
`else
  parameter int RW = 5,
`endif
  localparam int WW = $clog2(32 / WIDTH),
  localparam int AW = RW + WW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  input  logic [RW-1:0]    i_rreg0,
  input  logic [RW-1:0]    i_rreg1,
  output logic             o_ready,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [RW-1:0]    i_wreg0,
  input  logic [RW-1:0]    i_wreg1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen
);

  localparam int LW = $clog2(WIDTH);
  // Phase of the read cycle counter within one RAM word period.
  localparam logic [LW-1:0] PH_RS1  = LW'(0);
  localparam logic [LW-1:0] PH_RS2  = LW'(1);
  localparam logic [LW-1:0] PH_HOLD = LW'(2);
  localparam logic [LW-1:0] PH_LOAD = LW'(3);
  localparam logic [LW-1:0] PH_LAST = {LW{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} rd_state_t;

  function automatic logic [AW-1:0] ram_addr(input logic [RW-1:0] idx, input logic [4:0] bitpos);
    return AW'({idx, bitpos} >> LW);
  endfunction

  rd_state_t        state_r;
  logic [5:0]       cyc_r;
  logic [RW-1:0]    rreg0_r, rreg1_r;
  logic [WIDTH-1:0] hold0_r, shift0_r, shift1_r;
  logic             ready_r, ren_r;
  logic [AW-1:0]    raddr_r;
  logic             active_s, in_win_s;
  logic [5:0]       c_s;
  logic [LW-1:0]    phase_s;
  logic [RW-1:0]    rsel_s;

  logic [4:0]       wcnt_r;
  logic [WIDTH-1:0] acc0_r, acc1_r, word0_s, word1_s;
  logic             boundary_s;
  logic             pend1_r;
  logic [AW-1:0]    paddr1_r;
  logic [WIDTH-1:0] pdata1_r;
  logic             wen_r;
  logic [AW-1:0]    waddr_r;
  logic [WIDTH-1:0] wdata_r;

  // Cycle position within the current read and the register to fetch this cycle.
  always_comb begin
    active_s = (state_r == BUSY) || i_rreq;
    c_s      = (state_r == BUSY) ? cyc_r : 6'd0;
    phase_s  = c_s[LW-1:0];
    in_win_s = active_s && !c_s[5];
    if (phase_s == PH_RS1) begin
      rsel_s = (state_r == BUSY) ? rreg0_r : i_rreg0;
    end else begin
      rsel_s = rreg1_r;
    end
  end

  // Read FSM: fetch rs1/rs2 words, hold rs1 one cycle so both streams load together, then shift out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= IDLE;
      cyc_r    <= 6'd0;
      rreg0_r  <= {RW{1'b0}};
      rreg1_r  <= {RW{1'b0}};
      hold0_r  <= {WIDTH{1'b0}};
      shift0_r <= {WIDTH{1'b0}};
      shift1_r <= {WIDTH{1'b0}};
      ready_r  <= 1'b0;
      ren_r    <= 1'b0;
      raddr_r  <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (i_rreq) begin
            state_r <= BUSY;
            rreg0_r <= i_rreg0;
            rreg1_r <= i_rreg1;
            cyc_r   <= 6'd1;
          end
        end
        BUSY: begin
          cyc_r <= cyc_r + 6'd1;
          if (cyc_r == 6'd35) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      ready_r <= (state_r == BUSY) && (cyc_r == 6'd3);
      ren_r   <= in_win_s && ((phase_s == PH_RS1) || (phase_s == PH_RS2));
      if (in_win_s) begin
        raddr_r <= ram_addr(rsel_s, c_s[4:0]);
      end
      if (in_win_s && (phase_s == PH_HOLD)) begin
        hold0_r <= i_rdata;
      end
      if (in_win_s && (phase_s == PH_LOAD)) begin
        shift0_r <= hold0_r;
        shift1_r <= i_rdata;
      end else begin
        shift0_r <= {1'b0, shift0_r[WIDTH-1:1]};
        shift1_r <= {1'b0, shift1_r[WIDTH-1:1]};
      end
    end
  end

  // Complete words as seen in the boundary cycle, including the bit arriving now.
  always_comb begin
    boundary_s = (wcnt_r[LW-1:0] == PH_LAST);
    word0_s = acc0_r;
    word0_s[WIDTH-1] = i_wdata0;
    word1_s = acc1_r;
    word1_s[WIDTH-1] = i_wdata1;
  end

  // Write path: accumulate serial bits; port 0 writes one cycle after a boundary, port 1 one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wcnt_r   <= 5'd0;
      acc0_r   <= {WIDTH{1'b0}};
      acc1_r   <= {WIDTH{1'b0}};
      pend1_r  <= 1'b0;
      paddr1_r <= {AW{1'b0}};
      pdata1_r <= {WIDTH{1'b0}};
      wen_r    <= 1'b0;
      waddr_r  <= {AW{1'b0}};
      wdata_r  <= {WIDTH{1'b0}};
    end else begin
      if (i_wen0 || i_wen1) begin
        wcnt_r <= wcnt_r + 5'd1;
        if (i_wen0) begin
          acc0_r[wcnt_r[LW-1:0]] <= i_wdata0;
        end
        if (i_wen1) begin
          acc1_r[wcnt_r[LW-1:0]] <= i_wdata1;
        end
      end else begin
        wcnt_r <= 5'd0;
      end
      if (boundary_s) begin
        wen_r    <= i_wen0 && (i_wreg0 != {RW{1'b0}});
        waddr_r  <= ram_addr(i_wreg0, wcnt_r);
        wdata_r  <= word0_s;
        pend1_r  <= i_wen1;
        paddr1_r <= ram_addr(i_wreg1, wcnt_r);
        pdata1_r <= word1_s;
      end else if (pend1_r) begin
        wen_r   <= 1'b1;
        waddr_r <= paddr1_r;
        wdata_r <= pdata1_r;
        pend1_r <= 1'b0;
      end else begin
        wen_r <= 1'b0;
      end
    end
  end

  assign o_ready  = ready_r;
  assign o_rdata0 = shift0_r[0];
  assign o_rdata1 = shift1_r[0];
  assign o_ren    = ren_r;
  assign o_raddr  = raddr_r;
  assign o_wen    = wen_r;
  assign o_waddr  = waddr_r;
  assign o_wdata  = wdata_r;

endmodule

// File: tb/tb_serv_rf_ram_port.sv
// Scoreboard bench for serv_rf_ram_port: WIDTH=8, 6-bit register indices, behavioural RAM model.
module tb_serv_rf_ram_port;
  localparam int WIDTH = 8;
  localparam int RW = 6;
  localparam int AW = 8;

  typedef struct {logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic [31:0] d0; logic [31:0] d1;} rd_t;

  logic clk, rst, rreq, ready, rdata0, rdata1;
  logic [RW-1:0] rreg0, rreg1, wreg0, wreg1;
  logic wen0, wen1, wdata0, wdata1, ren, wen;
  logic [AW-1:0] raddr, waddr;
  logic [WIDTH-1:0] rdata, wdata;
  logic [7:0] mem [0:255];

  wr_t wr_q[$];
  rd_t rd_q[$];
  int checks = 0;
  int errors = 0;
  logic rd_act = 1'b0;

  serv_rf_ram_port #(.WIDTH(WIDTH), .RW(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_rreq(rreq), .i_rreg0(rreg0), .i_rreg1(rreg1),
    .o_ready(ready), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .i_wen0(wen0), .i_wen1(wen1), .i_wreg0(wreg0), .i_wreg1(wreg1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata),
    .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple dual-port RAM, one-cycle read latency, old data on read-during-write.
  always @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
  end

  // Monitor: RAM writes and read streams are compared against the scoreboard queues.
  initial begin
    rd_t cur;
    wr_t exp;
    logic [31:0] got0, got1;
    int bitn;
    bitn = 0;
    got0 = 32'd0;
    got1 = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_act = 1'b0;
      end else begin
        if (wen) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL ram_write unexpected: got addr=%0d data=%h, want no write", waddr, wdata);
          end else begin
            exp = wr_q.pop_front();
            if (waddr !== exp.addr || wdata !== exp.data) begin
              errors++;
              $display("FAIL ram_write: got addr=%0d data=%h, want addr=%0d data=%h",
                       waddr, wdata, exp.addr, exp.data);
            end
          end
        end
        if (!rd_act && ready) begin
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_ready unexpected: got o_ready=1, want 0");
          end else begin
            cur = rd_q.pop_front();
            rd_act = 1'b1;
            bitn = 0;
          end
        end
        if (rd_act) begin
          got0[bitn] = rdata0;
          got1[bitn] = rdata1;
          bitn++;
          if (bitn == 32) begin
            rd_act = 1'b0;
            checks += 2;
            if (got0 !== cur.d0) begin
              errors++;
              $display("FAIL read_rs1: got %h, want %h", got0, cur.d0);
            end
            if (got1 !== cur.d1) begin
              errors++;
              $display("FAIL read_rs2: got %h, want %h", got1, cur.d1);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int r, input logic [31:0] v);
    for (int w = 0; w < 4; w++) mem[r*4+w] = v[w*8 +: 8];
  endtask

  task automatic start_read(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                            input logic [31:0] e0, input logic [31:0] e1);
    rd_t t;
    t.d0 = e0;
    t.d1 = e1;
    rd_q.push_back(t);
    rreq = 1'b1;
    rreg0 = r0;
    rreg1 = r1;
  endtask

  task automatic do_read(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                         input logic [31:0] e0, input logic [31:0] e1);
    start_read(r0, r1, e0, e1);
    tick();
    rreq = 1'b0;
    repeat (40) tick();
  endtask

  task automatic drive_bits(input logic e0, input logic e1,
                            input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                            input logic [31:0] d0, input logic [31:0] d1, input int nbits);
    wr_t t;
    for (int w = 0; w < nbits / 8; w++) begin
      if (e0 && r0 != 6'd0) begin
        t.addr = {r0, 2'(w)};
        t.data = d0[w*8 +: 8];
        wr_q.push_back(t);
      end
      if (e1) begin
        t.addr = {r1, 2'(w)};
        t.data = d1[w*8 +: 8];
        wr_q.push_back(t);
      end
    end
    for (int b = 0; b < nbits; b++) begin
      wen0 = e0;
      wen1 = e1;
      wreg0 = r0;
      wreg1 = r1;
      wdata0 = d0[b];
      wdata1 = d1[b];
      tick();
      rreq = 1'b0;
    end
    wen0 = 1'b0;
    wen1 = 1'b0;
    wdata0 = 1'b0;
    wdata1 = 1'b0;
  endtask

  initial begin
    logic [35:0] ren_mask, rdy_mask;
    logic [4:0] outs;
    rst = 1'b1;
    rreq = 1'b0;
    rreg0 = 6'd0;
    rreg1 = 6'd0;
    wen0 = 1'b0;
    wen1 = 1'b0;
    wreg0 = 6'd0;
    wreg1 = 6'd0;
    wdata0 = 1'b0;
    wdata1 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    preload(3, 32'hA5A50F0F);
    preload(2, 32'h12345678);
    repeat (3) tick();

    checks++;
    if ({ready, ren, wen, rdata0, rdata1, raddr, waddr, wdata} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0",
               {ready, ren, wen, rdata0, rdata1, raddr, waddr, wdata});
    end
    rst = 1'b0;
    tick();

    // Read x3/x2 while recording which cycles carry o_ren and o_ready.
    ren_mask = 36'd0;
    rdy_mask = 36'd0;
    start_read(6'd3, 6'd2, 32'hA5A50F0F, 32'h12345678);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      ren_mask[c] = ren;
      rdy_mask[c] = ready;
      tick();
      rreq = 1'b0;
    end
    checks += 2;
    if (ren_mask !== 36'h006060606) begin
      errors++;
      $display("FAIL ren_cycles: got %h, want %h", ren_mask, 36'h006060606);
    end
    if (rdy_mask !== 36'h000000010) begin
      errors++;
      $display("FAIL ready_cycle: got %h, want %h", rdy_mask, 36'h000000010);
    end
    repeat (4) tick();

    drive_bits(1'b1, 1'b0, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0, 32);
    repeat (4) tick();
    do_read(6'd5, 6'd3, 32'hDEADBEEF, 32'hA5A50F0F);

    drive_bits(1'b1, 1'b1, 6'd7, 6'd34, 32'h00000001, 32'h80000000, 32);
    repeat (4) tick();
    do_read(6'd7, 6'd34, 32'h00000001, 32'h80000000);

    drive_bits(1'b1, 1'b0, 6'd0, 6'd0, 32'hFFFFFFFF, 32'h0, 32);
    repeat (4) tick();
    do_read(6'd0, 6'd5, 32'h00000000, 32'hDEADBEEF);

    // Twelve bits only: word 0 lands, the partial word 1 must be dropped.
    drive_bits(1'b1, 1'b0, 6'd11, 6'd0, 32'h00000ABC, 32'h0, 12);
    repeat (2) tick();
    drive_bits(1'b1, 1'b0, 6'd11, 6'd0, 32'hCAFEF00D, 32'h0, 32);
    repeat (4) tick();
    do_read(6'd11, 6'd7, 32'hCAFEF00D, 32'h00000001);

    // Reset at cycle 10 of a read with a write in flight.
    start_read(6'd3, 6'd2, 32'hA5A50F0F, 32'h12345678);
    drive_bits(1'b1, 1'b0, 6'd9, 6'd0, 32'h000003C5, 32'h0, 10);
    rst = 1'b1;
    #1;
    outs = {ready, ren, wen, rdata0, rdata1};
    checks++;
    if (outs !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, want 00000", outs);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    do_read(6'd3, 6'd2, 32'hA5A50F0F, 32'h12345678);
    repeat (5) tick();

    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || rd_act) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes %0d reads pending, want 0 0",
               wr_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
